dir_sched: RTL and testbench



---
 rtl/dir_sched_pkg.sv | 31 +++
 rtl/dir_sched_fifo.sv | 55 +++++
 rtl/dir_sched.sv | 120 ++++++++++++
 tb/tb_dir_sched.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dir_sched_pkg.sv
// Shared direction codes, scheduler states and direction helpers for the snake-game scheduler.
package dir_sched_pkg;

   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_DOWN  = 2'b01;
   localparam logic [1:0] DIR_LEFT  = 2'b10;
   localparam logic [1:0] DIR_RIGHT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10
   } state_e;

   // Opposite directions share bit 1 and differ only in bit 0.
   function automatic logic dir_opposite(input logic [1:0] a, input logic [1:0] b);
      return (a[1] == b[1]) && (a[0] != b[0]);
   endfunction

   function automatic logic [1:0] key_code(input logic [3:0] k);
      logic [1:0] code;
      case (k)
         4'b0010: code = DIR_DOWN;
         4'b0100: code = DIR_LEFT;
         4'b1000: code = DIR_RIGHT;
         default: code = DIR_UP;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/dir_sched_fifo.sv
// Synchronous DEPTH x 2 direction queue exposing both head and most recently written (tail) entry.
module dir_sched_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [1:0]               data_i,
   output logic [1:0]               head_o,
   output logic [1:0]               tail_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [1:0]    mem_q [DEPTH];
   logic [AW-1:0] rd_ptr_q;
   logic [AW-1:0] wr_ptr_q;
   logic [AW:0]   count_q;
   logic          do_push;
   logic          do_pop;

   always_comb begin
      do_pop  = pop_i && (count_q != '0);
      do_push = push_i && ((count_q != FULL) || do_pop);
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign tail_o  = mem_q[wr_ptr_q - AW'(1)];
   assign count_o = count_q;

endmodule

// File: rtl/dir_sched.sv
// Direction scheduler: key edge detection, queued direction changes and periodic move strobe.
module dir_sched
   import dir_sched_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned STEP_DIV = 12500000,
   parameter int unsigned CNT_W    = 24
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [3:0]             keys,
   input  logic                   pause_key,
   input  logic                   halt,
   output logic                   step,
   output logic [1:0]             dir,
   output logic                   running,
   output logic [$clog2(DEPTH):0] q_cnt
);

   localparam int unsigned QW = $clog2(DEPTH) + 1;
   localparam logic [QW-1:0]    FULL = QW'(DEPTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_DIV - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       dir_q, dir_d;
   logic             step_q, step_d;
   logic             running_q;
   logic [3:0]       keys_q;
   logic             pause_q;

   logic [3:0]       rise;
   logic             key_ev, pause_ev, wrap;
   logic [1:0]       key_dir, ref_dir, head, tail;
   logic             push, pop;
   logic [QW-1:0]    fifo_cnt;

   dir_sched_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .flush_i (halt),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (key_dir),
      .head_o  (head),
      .tail_o  (tail),
      .count_o (fifo_cnt)
   );

   always_comb begin
      rise     = keys & ~keys_q;
      key_ev   = (rise != '0) && ((rise & (rise - 4'd1)) == '0);
      key_dir  = key_code(rise);
      pause_ev = pause_key & ~pause_q;
      wrap     = (state_q == ST_RUN) && (cnt_q == LAST);
      // Reference is the last direction that will be in effect: queue tail, else current dir.
      ref_dir  = (fifo_cnt != '0) ? tail : dir_q;
      pop      = !halt && wrap && (fifo_cnt != '0);
      push     = !halt && (state_q == ST_RUN) && key_ev
                 && (key_dir != ref_dir) && !dir_opposite(key_dir, ref_dir)
                 && ((fifo_cnt != FULL) || pop);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      step_d  = 1'b0;
      if (halt) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_d = '0;
               if (key_ev) begin
                  dir_d   = key_dir;
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
               step_d = wrap;
               if (pop)      dir_d   = head;
               if (pause_ev) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
               if (pause_ev) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         dir_q     <= DIR_UP;
         step_q    <= 1'b0;
         running_q <= 1'b0;
         keys_q    <= '1;
         pause_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dir_q     <= dir_d;
         step_q    <= step_d;
         running_q <= (state_d == ST_RUN);
         keys_q    <= keys;
         pause_q   <= pause_key;
      end
   end

   assign step    = step_q;
   assign dir     = dir_q;
   assign running = running_q;
   assign q_cnt   = fifo_cnt;

endmodule

// File: tb/tb_dir_sched.sv
// Directed bench for dir_sched with STEP_DIV=4, DEPTH=4; expected values hand-derived per cycle.
module tb_dir_sched;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] keys = 4'b0000;
   logic       pause_key = 1'b0;
   logic       halt = 1'b0;
   logic       step;
   logic [1:0] dir;
   logic       running;
   logic [2:0] q_cnt;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int unsigned n;
   int unsigned seen;

   dir_sched #(.DEPTH(4), .STEP_DIV(4), .CNT_W(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .keys      (keys),
      .pause_key (pause_key),
      .halt      (halt),
      .step      (step),
      .dir       (dir),
      .running   (running),
      .q_cnt     (q_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input logic [3:0] v);
      keys = v;
      tick();
   endtask

   task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Ticks until step is seen; 20 means the strobe never came.
   task automatic wait_step(output int unsigned cyc);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (!step && cyc < 20);
   endtask

   initial begin
      // reset state
      tick();
      tick();
      chk("rst_dir", dir, 0);
      chk("rst_step", step, 0);
      chk("rst_running", running, 0);
      chk("rst_qcnt", q_cnt, 0);
      rst = 1'b0;
      tick();
      chk("idle_running", running, 0);

      // IDLE start
      apply(4'b0010);
      chk("start_dir", dir, 1);
      chk("start_running", running, 1);
      chk("start_step", step, 0);
      keys = 4'b0000;
      wait_step(n);
      chk("first_step_lat", n, 4);
      wait_step(n);
      chk("step_period", n, 4);

      // reverse / duplicate filtering, dir=01
      apply(4'b0001);
      chk("rev_drop_q", q_cnt, 0);
      apply(4'b0010);
      chk("dup_drop_q", q_cnt, 0);
      apply(4'b0100);
      chk("accept_q", q_cnt, 1);
      apply(4'b0000);
      chk("pop_step", step, 1);
      chk("pop_dir", dir, 2);
      chk("pop_q", q_cnt, 0);
      apply(4'b0010);
      keys = 4'b0000;
      wait_step(n);
      chk("back_to_01_lat", n, 3);
      chk("back_to_01_dir", dir, 1);

      // queue fill, pop+push on step edge, full drop, drain order
      apply(4'b0100);
      apply(4'b0001);
      apply(4'b1000);
      apply(4'b0010);
      chk("fill_pp_step", step, 1);
      chk("fill_pp_dir", dir, 2);
      chk("fill_pp_q", q_cnt, 3);
      apply(4'b0100);
      chk("fill_full_q", q_cnt, 4);
      apply(4'b0001);
      chk("full_drop_q", q_cnt, 4);
      keys = 4'b0000;
      wait_step(n);
      chk("drain1_lat", n, 2);
      chk("drain1_dir", dir, 0);
      chk("drain1_q", q_cnt, 3);
      wait_step(n);
      chk("drain2_dir", dir, 3);
      chk("drain2_q", q_cnt, 2);
      wait_step(n);
      chk("drain3_dir", dir, 1);
      chk("drain3_q", q_cnt, 1);
      wait_step(n);
      chk("drain4_lat", n, 4);
      chk("drain4_dir", dir, 2);
      chk("drain4_q", q_cnt, 0);

      // multi-key rise ignored
      apply(4'b0011);
      chk("multi_q", q_cnt, 0);
      chk("multi_dir", dir, 2);
      apply(4'b0000);
      wait_step(n);
      chk("multi_resync", n, 2);

      // pause two cycles after a step
      tick();
      pause_key = 1'b1;
      tick();
      chk("pause_running", running, 0);
      pause_key = 1'b0;
      apply(4'b0001);
      apply(4'b0000);
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (step) seen++;
      end
      chk("pause_nostep", seen, 0);
      chk("pause_key_drop_q", q_cnt, 0);
      pause_key = 1'b1;
      tick();
      chk("resume_running", running, 1);
      pause_key = 1'b0;
      wait_step(n);
      chk("resume_lat", n, 2);
      chk("resume_dir", dir, 2);

      // halt with three queued entries, on what would be a step edge
      apply(4'b0001);
      apply(4'b0100);
      apply(4'b0001);
      chk("pre_halt_q", q_cnt, 3);
      keys = 4'b0000;
      halt = 1'b1;
      tick();
      chk("halt_q", q_cnt, 0);
      chk("halt_running", running, 0);
      chk("halt_step", step, 0);
      chk("halt_dir", dir, 2);
      halt = 1'b0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (step) seen++;
      end
      chk("idle_nostep", seen, 0);
      apply(4'b1000);
      chk("restart_dir", dir, 3);
      chk("restart_running", running, 1);
      apply(4'b0001);
      chk("restart_q", q_cnt, 1);

      // rst mid-RUN with a key held through reset
      keys = 4'b0100;
      rst = 1'b1;
      tick();
      chk("mrst_dir", dir, 0);
      chk("mrst_step", step, 0);
      chk("mrst_q", q_cnt, 0);
      chk("mrst_running", running, 0);
      tick();
      rst = 1'b0;
      tick();
      tick();
      tick();
      chk("held_running", running, 0);
      chk("held_dir", dir, 0);
      apply(4'b0000);
      apply(4'b1000);
      chk("post_rst_dir", dir, 3);
      chk("post_rst_running", running, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
